// File: rtl/nf_instr_mem_pkg.sv
// rtl/nf_instr_mem_pkg.sv - shared types and constants for the instruction memory
package nf_instr_mem_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } ld_state_e;

  // RV32I canonical nop: addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [7:0]  data,
                                              input logic [1:0]  idx);
    logic [31:0] r;
    r = word;
    r[{idx, 3'b000} +: 8] = data;
    return r;
  endfunction

endpackage

// File: rtl/nf_instr_ram.sv
// rtl/nf_instr_ram.sv - word array with one synchronous write and one asynchronous read port
module nf_instr_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  // Contents survive reset so a loaded program outlives a CPU restart.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nf_instr_mem.sv
// rtl/nf_instr_mem.sv - CPU instruction memory with a byte-stream program loader
module nf_instr_mem #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] NOP   = nf_instr_mem_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              instr_addr,
  output logic [31:0]              instr,
  output logic                     cpu_resetn,
  input  logic                     ld_start,
  input  logic                     ld_end,
  input  logic [7:0]               ld_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  output logic                     ld_overflow,
  output logic [$clog2(DEPTH):0]   words_loaded
);

  import nf_instr_mem_pkg::*;

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] WL_ONE = 1;

  ld_state_e   state;
  ld_state_e   state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [31:0] asm_next;
  logic [2:0]  pending;
  logic        run_q;
  logic        xfer;
  logic        word_done;
  logic        flush;
  logic        wr_req;
  logic        full;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic        addr_in_range;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^instr_addr[1:0];
  assign addr_in_range    = (instr_addr[31:AW+2] == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (ld_start) begin
      state_next = LOAD;
    end else if (state == LOAD && ld_end) begin
      state_next = RUN;
    end
  end

  always_comb begin
    ld_ready = (state == LOAD);
    instr    = NOP;
    if (state == RUN && addr_in_range) begin
      instr = ram_rdata;
    end
  end

  // A byte arriving alongside ld_end is folded in before the flush.
  always_comb begin
    xfer      = ld_valid && ld_ready;
    asm_next  = xfer ? insert_byte(asm_word, ld_data, byte_cnt) : asm_word;
    pending   = {1'b0, byte_cnt} + {2'b00, xfer};
    word_done = xfer && (byte_cnt == 2'd3);
    flush     = (state == LOAD) && ld_end && !word_done && (pending != 3'd0);
    wr_req    = (word_done || flush) && !ld_start;
    full      = words_loaded[AW];
    ram_we    = wr_req && !full && resetn;
  end

  always_ff @(posedge clk) begin
    if (!resetn || ld_start) begin
      byte_cnt     <= 2'd0;
      asm_word     <= 32'd0;
      words_loaded <= '0;
      ld_overflow  <= 1'b0;
    end else if (state == LOAD) begin
      if (word_done || ld_end) begin
        byte_cnt <= 2'd0;
        asm_word <= 32'd0;
      end else if (xfer) begin
        byte_cnt <= byte_cnt + 2'd1;
        asm_word <= asm_next;
      end
      if (wr_req) begin
        if (full) begin
          ld_overflow <= 1'b1;
        end else begin
          words_loaded <= words_loaded + WL_ONE;
        end
      end
    end
  end

  // Two-stage release so the CPU sees reset for a full cycle after RUN resumes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_q      <= 1'b0;
      cpu_resetn <= 1'b0;
    end else begin
      run_q      <= (state == RUN) && (state_next == RUN);
      cpu_resetn <= run_q && (state_next == RUN);
    end
  end

  nf_instr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (words_loaded[AW-1:0]),
    .wdata (asm_next),
    .raddr (instr_addr[AW+1:2]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_nf_instr_mem.sv
// tb/tb_nf_instr_mem.sv - scoreboard bench for nf_instr_mem at DEPTH 1024 and DEPTH 4
module tb_nf_instr_mem;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int S_INSTR = 0, S_CPU = 1, S_RDY = 2, S_OVF = 3, S_WL = 4, B_OFS = 10;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ld_start = 1'b0;
  logic        ld_end = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic [31:0] instr_addr = 32'h0;

  logic [31:0] instr_a, instr_b;
  logic        cpu_resetn_a, cpu_resetn_b;
  logic        ld_ready_a, ld_ready_b;
  logic        ld_overflow_a, ld_overflow_b;
  logic [10:0] words_a;
  logic [2:0]  words_b;

  nf_instr_mem #(.DEPTH(1024)) dut_a (
    .clk(clk), .resetn(resetn), .instr_addr(instr_addr), .instr(instr_a),
    .cpu_resetn(cpu_resetn_a), .ld_start(ld_start), .ld_end(ld_end),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready_a),
    .ld_overflow(ld_overflow_a), .words_loaded(words_a)
  );

  nf_instr_mem #(.DEPTH(4)) dut_b (
    .clk(clk), .resetn(resetn), .instr_addr(instr_addr), .instr(instr_b),
    .cpu_resetn(cpu_resetn_b), .ld_start(ld_start), .ld_end(ld_end),
    .ld_data(ld_data), .ld_valid(ld_valid), .ld_ready(ld_ready_b),
    .ld_overflow(ld_overflow_b), .words_loaded(words_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] sample(input int sig);
    case (sig)
      S_INSTR:         return instr_a;
      S_CPU:           return {31'b0, cpu_resetn_a};
      S_RDY:           return {31'b0, ld_ready_a};
      S_OVF:           return {31'b0, ld_overflow_a};
      S_WL:            return {21'b0, words_a};
      B_OFS + S_INSTR: return instr_b;
      B_OFS + S_CPU:   return {31'b0, cpu_resetn_b};
      B_OFS + S_RDY:   return {31'b0, ld_ready_b};
      B_OFS + S_OVF:   return {31'b0, ld_overflow_b};
      B_OFS + S_WL:    return {29'b0, words_b};
      default:         return 32'hxxxxxxxx;
    endcase
  endfunction

  // Outputs are sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    while (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_act = sample(mon_e.sig);
      checks++;
      if (mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s (sig %0d): actual=%h expected=%h", mon_e.name, mon_e.sig, mon_act, mon_e.val);
      end
    end
  end

  task automatic push(input string name, input int sig, input logic [31:0] val);
    exp_q.push_back('{name, sig, val});
  endtask

  task automatic both(input string name, input int sig, input logic [31:0] va, input logic [31:0] vb);
    push({name, "_a"}, sig, va);
    push({name, "_b"}, sig + B_OFS, vb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic pulse_end();
    ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
  endtask

  task automatic read_both(input string name, input logic [31:0] addr,
                           input logic [31:0] va, input logic [31:0] vb);
    instr_addr = addr;
    both(name, S_INSTR, va, vb);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ovf_words [5];
    ovf_words[0] = 32'h11223344;
    ovf_words[1] = 32'h55667788;
    ovf_words[2] = 32'h99AABBCC;
    ovf_words[3] = 32'hDDEEFF00;
    ovf_words[4] = 32'hCAFEBABE;

    // reset state and cpu_resetn release timing
    tick();
    tick();
    both("rst_cpu", S_CPU, 0, 0);
    both("rst_wl", S_WL, 0, 0);
    both("rst_ovf", S_OVF, 0, 0);
    both("rst_rdy", S_RDY, 0, 0);
    resetn = 1'b1;
    tick();
    both("rel_cpu_clk1", S_CPU, 0, 0);
    tick();
    both("rel_cpu_clk2", S_CPU, 1, 1);

    // single word load then release
    pulse_start();
    both("ld_rdy", S_RDY, 1, 1);
    both("ld_cpu", S_CPU, 0, 0);
    both("ld_wl0", S_WL, 0, 0);
    both("ld_instr_nop", S_INSTR, NOP, NOP);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    both("wl_one", S_WL, 1, 1);
    pulse_end();
    both("end_rdy", S_RDY, 0, 0);
    both("end_cpu_clk0", S_CPU, 0, 0);
    tick();
    both("end_cpu_clk1", S_CPU, 0, 0);
    tick();
    both("end_cpu_clk2", S_CPU, 1, 1);
    read_both("mem0_first", 32'd0, 32'h00100013, 32'h00100013);

    // two words plus a two-byte partial
    pulse_start();
    send_word(32'h00100013);
    send_word(32'h12345678);
    both("wl_two", S_WL, 2, 2);
    instr_addr = 32'd4;
    both("load_instr_nop", S_INSTR, NOP, NOP);
    send_byte(8'hAA); send_byte(8'hBB);
    both("wl_partial_pending", S_WL, 2, 2);
    pulse_end();
    both("wl_after_flush", S_WL, 3, 3);
    for (int a = 4; a < 8; a++) begin
      read_both("rd_mem1", a, 32'h12345678, 32'h12345678);
    end
    read_both("rd_padded", 32'd8, 32'h0000BBAA, 32'h0000BBAA);
    read_both("rd_oor_4depth", 32'd4096, NOP, NOP);
    read_both("rd_oor_top", 32'hFFFFFFFC, NOP, NOP);
    instr_addr = 32'd16;
    push("rd_oor_b_16", B_OFS + S_INSTR, NOP);
    tick();

    // byte transfer coincident with ld_end
    pulse_start();
    send_byte(8'hCC);
    ld_valid = 1'b1; ld_data = 8'hDD; ld_end = 1'b1;
    tick();
    ld_valid = 1'b0; ld_end = 1'b0;
    both("merge_wl", S_WL, 1, 1);
    both("merge_rdy", S_RDY, 0, 0);
    read_both("merge_word", 32'd0, 32'h0000DDCC, 32'h0000DDCC);

    // five words: DEPTH 4 instance overflows
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_word(ovf_words[i]);
    end
    both("four_wl", S_WL, 4, 4);
    both("four_ovf", S_OVF, 0, 0);
    send_word(ovf_words[4]);
    both("five_wl", S_WL, 5, 4);
    both("five_ovf", S_OVF, 0, 1);
    pulse_end();
    both("ovf_sticky", S_OVF, 0, 1);
    read_both("ovf_mem0", 32'd0, ovf_words[0], ovf_words[0]);
    read_both("ovf_mem3", 32'd12, ovf_words[3], ovf_words[3]);
    read_both("ovf_mem4", 32'd16, ovf_words[4], NOP);

    // ld_start and ld_end together: start wins and clears load status
    ld_start = 1'b1; ld_end = 1'b1;
    tick();
    ld_start = 1'b0; ld_end = 1'b0;
    both("start_win_rdy", S_RDY, 1, 1);
    both("start_win_ovf", S_OVF, 0, 0);
    both("start_win_wl", S_WL, 0, 0);

    // reset mid-word abandons the partial word
    send_byte(8'hEE); send_byte(8'hFF);
    resetn = 1'b0; ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
    both("midrst_rdy", S_RDY, 0, 0);
    both("midrst_cpu", S_CPU, 0, 0);
    both("midrst_wl", S_WL, 0, 0);
    resetn = 1'b1;
    tick();
    both("midrst_cpu_clk1", S_CPU, 0, 0);
    tick();
    both("midrst_cpu_clk2", S_CPU, 1, 1);
    read_both("midrst_mem0", 32'd0, ovf_words[0], ovf_words[0]);

    // ld_valid held in RUN is ignored
    ld_valid = 1'b1; ld_data = 8'h55; instr_addr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      both("run_valid_rdy", S_RDY, 0, 0);
      tick();
    end
    ld_valid = 1'b0;
    both("run_valid_wl", S_WL, 0, 0);
    both("run_valid_mem0", S_INSTR, ovf_words[0], ovf_words[0]);
    tick();
    tick();

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: actual=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
